// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Carries the byte address, store data, size/sign controls and the load handshake.
interface data_memory_sized_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH+1:0] Address;
  logic [31:0]           WriteData;
  logic                  MemoryRead;
  logic                  MemoryWrite;
  logic [1:0]            Size;
  logic                  Unsigned;
  logic                  Ready;
  logic [31:0]           ReadData;
  logic                  ReadValid;
  logic                  Error;

  modport master (
    output Address, WriteData, MemoryRead, MemoryWrite, Size, Unsigned,
    input  Ready, ReadData, ReadValid, Error
  );

  modport slave (
    input  Address, WriteData, MemoryRead, MemoryWrite, Size, Unsigned,
    output Ready, ReadData, ReadValid, Error
  );
endinterface

// File: rtl/data_memory_sized.sv
// Big-endian byte-addressed data memory with byte/half/word loads and stores and an
// optional fixed number of wait states per load; illegal requests pulse Error.
module data_memory_sized #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 0
) (
  input logic                Clock,
  input logic                Reset,
  data_memory_sized_if.slave bus
);
  localparam int         DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_COUNT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, WAITING} stateType;

  stateType              stateReg, stateNext;
  logic [3:0]            countReg, countNext;
  logic [ADDR_WIDTH+1:0] addrReg;
  logic [1:0]            sizeReg;
  logic                  unsignedReg;

  logic [31:0]           rawWordReg;
  logic [1:0]            rdOffsetReg;
  logic [1:0]            rdSizeReg;
  logic                  rdUnsignedReg;
  logic                  readValidReg;
  logic                  errorReg;

  logic                  ready;
  logic                  accept;
  logic                  illegal;
  logic                  loadAccept;
  logic                  storeAccept;
  logic                  loadDone;
  logic                  loadCapture;
  logic [ADDR_WIDTH+1:0] loadAddr;
  logic [1:0]            loadSize;
  logic                  loadUnsigned;
  logic [3:0]            laneEnable;
  logic [31:0]           laneData;
  logic [7:0]            readLane [4];

  assign ready   = (stateReg == IDLE);
  assign accept  = ready & (bus.MemoryRead | bus.MemoryWrite);
  assign illegal = (bus.MemoryRead & bus.MemoryWrite)
                 | (bus.Size == 2'b11)
                 | ((bus.Size == 2'b01) & bus.Address[0])
                 | ((bus.Size == 2'b10) & (bus.Address[1:0] != 2'b00));

  assign loadAccept  = accept & bus.MemoryRead & ~illegal;
  assign storeAccept = accept & bus.MemoryWrite & ~illegal;
  assign loadDone    = (stateReg == WAITING) && (countReg == 4'd1);
  assign loadCapture = (WAIT_STATES == 0) ? loadAccept : loadDone;

  // During a wait the request lines may change, so the read uses the latched copy.
  assign loadAddr     = (stateReg == WAITING) ? addrReg     : bus.Address;
  assign loadSize     = (stateReg == WAITING) ? sizeReg     : bus.Size;
  assign loadUnsigned = (stateReg == WAITING) ? unsignedReg : bus.Unsigned;

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    case (stateReg)
      IDLE: begin
        if (loadAccept && (WAIT_STATES != 0)) begin
          stateNext = WAITING;
          countNext = WAIT_COUNT;
        end
      end
      WAITING: begin
        countNext = countReg - 4'd1;
        if (countReg == 4'd1) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg <= IDLE;
      countReg <= 4'd0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (loadAccept && ready) begin
      addrReg     <= bus.Address;
      sizeReg     <= bus.Size;
      unsignedReg <= bus.Unsigned;
    end
  end

  // Lane 3 holds bits 31:24, i.e. byte offset 0 in big-endian order.
  always_comb begin
    laneEnable = 4'b0000;
    laneData   = bus.WriteData;
    case (bus.Size)
      2'b00: begin
        laneEnable = 4'b1000 >> bus.Address[1:0];
        laneData   = {4{bus.WriteData[7:0]}};
      end
      2'b01: begin
        laneEnable = bus.Address[1] ? 4'b0011 : 4'b1100;
        laneData   = {2{bus.WriteData[15:0]}};
      end
      2'b10:   laneEnable = 4'b1111;
      default: laneEnable = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : laneGen
    logic [7:0] laneMem [DEPTH];

    always_ff @(posedge Clock) begin
      if (storeAccept && laneEnable[gi]) begin
        laneMem[bus.Address[ADDR_WIDTH+1:2]] <= laneData[gi*8 +: 8];
      end
    end

    assign readLane[gi] = laneMem[loadAddr[ADDR_WIDTH+1:2]];
  end

  // Raw word and lane controls are registered; extension happens after the register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rawWordReg    <= 32'd0;
      rdOffsetReg   <= 2'b00;
      rdSizeReg     <= 2'b00;
      rdUnsignedReg <= 1'b0;
      readValidReg  <= 1'b0;
      errorReg      <= 1'b0;
    end else begin
      readValidReg <= loadCapture;
      errorReg     <= accept & illegal;
      if (loadCapture) begin
        rawWordReg    <= {readLane[3], readLane[2], readLane[1], readLane[0]};
        rdOffsetReg   <= loadAddr[1:0];
        rdSizeReg     <= loadSize;
        rdUnsignedReg <= loadUnsigned;
      end
    end
  end

  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] offset,
                                             input logic [1:0] size, input logic isUnsigned);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    case (offset)
      2'd0:    byteVal = word[31:24];
      2'd1:    byteVal = word[23:16];
      2'd2:    byteVal = word[15:8];
      default: byteVal = word[7:0];
    endcase
    halfVal = offset[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   result = isUnsigned ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
      2'b01:   result = isUnsigned ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
      default: result = word;
    endcase
    return result;
  endfunction

  assign bus.Ready     = ready;
  assign bus.ReadValid = readValidReg;
  assign bus.Error     = errorReg;
  assign bus.ReadData  = extendLoad(rawWordReg, rdOffsetReg, rdSizeReg, rdUnsignedReg);
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: a zero-wait instance and a three-wait instance
// exercised side by side; status is compared as {Ready, ReadValid, Error, ReadData}.
module tb_data_memory_sized;
  localparam int AW = 6;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  data_memory_sized_if #(.ADDR_WIDTH(AW)) bus0 ();
  data_memory_sized_if #(.ADDR_WIDTH(AW)) bus3 ();

  data_memory_sized #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .bus(bus0)
  );
  data_memory_sized #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(bus3)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  logic [34:0] expected;
  logic [34:0] observed;
  logic [31:0] last0;

  function automatic logic [34:0] status0();
    return {bus0.Ready, bus0.ReadValid, bus0.Error, bus0.ReadData};
  endfunction

  function automatic logic [34:0] status3();
    return {bus3.Ready, bus3.ReadValid, bus3.Error, bus3.ReadData};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic req0(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd);
    bus0.MemoryRead = rd; bus0.MemoryWrite = wr; bus0.Address = addr;
    bus0.Size = size; bus0.Unsigned = uns; bus0.WriteData = wd;
    $display("t=%0t bus0 rd=%b wr=%b addr=%h size=%b uns=%b wdata=%h", $time, rd, wr, addr, size, uns, wd);
  endtask

  task automatic req3(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd);
    bus3.MemoryRead = rd; bus3.MemoryWrite = wr; bus3.Address = addr;
    bus3.Size = size; bus3.Unsigned = uns; bus3.WriteData = wd;
    $display("t=%0t bus3 rd=%b wr=%b addr=%h size=%b uns=%b wdata=%h", $time, rd, wr, addr, size, uns, wd);
  endtask

  task automatic idle0();
    bus0.MemoryRead = 1'b0; bus0.MemoryWrite = 1'b0;
  endtask

  task automatic idle3();
    bus3.MemoryRead = 1'b0; bus3.MemoryWrite = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus0.MemoryRead = 1'b1; bus0.Size = 2'b10; bus0.Address = 8'h00;
    bus3.MemoryRead = 1'b1; bus3.Size = 2'b10; bus3.Address = 8'h00;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        Reset = 1'b0;
        idle0();
        idle3();
      end
      tick();
      expected = {3'b100, 32'h0};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL reset_bus0 cycle %0d: got %h, expected %h", c, observed, expected);
      end
      observed = status3();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL reset_bus3 cycle %0d: got %h, expected %h", c, observed, expected);
      end
    end
    last0 = 32'h0;
  endtask

  task automatic test_load_store();
    logic [7:0]  addrs [7] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h10, 8'h10, 8'h13};
    logic [1:0]  sizes [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic        unss  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [7] = '{32'h80017FFF, 32'hFFFFFF80, 32'h00000001, 32'h00007FFF,
                               32'hFFFF8001, 32'h00008001, 32'hFFFFFFFF};
    req0(1'b0, 1'b1, 8'h10, 2'b10, 1'b0, 32'h80017FFF);
    tick();
    idle0();
    expected = {3'b100, last0};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL sw_0x10: got %h, expected %h", observed, expected);
    end
    for (int i = 0; i < 7; i++) begin
      req0(1'b1, 1'b0, addrs[i], sizes[i], unss[i], 32'h0);
      tick();
      idle0();
      expected = {3'b110, exps[i]};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL load_%0d addr %h: got %h, expected %h", i, addrs[i], observed, expected);
      end
      tick();
      expected = {3'b100, exps[i]};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL load_hold_%0d: got %h, expected %h", i, observed, expected);
      end
      last0 = exps[i];
    end
  endtask

  task automatic test_partial_store();
    req0(1'b0, 1'b1, 8'h13, 2'b00, 1'b0, 32'hFFFFFFAB);
    tick();
    req0(1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
    expected = {3'b100, last0};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL sb_0x13: got %h, expected %h", observed, expected);
    end
    tick();
    expected = {3'b110, 32'h80017FAB};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL lw_after_sb: got %h, expected %h", observed, expected);
    end
    req0(1'b0, 1'b1, 8'h10, 2'b01, 1'b0, 32'hFFFF1234);
    tick();
    req0(1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
    tick();
    idle0();
    expected = {3'b110, 32'h12347FAB};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL lw_after_sh: got %h, expected %h", observed, expected);
    end
    last0 = 32'h12347FAB;
  endtask

  task automatic test_illegal();
    logic       rds   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       wrs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] addrs [6] = '{8'h11, 8'h13, 8'h10, 8'h10, 8'h12, 8'h10};
    logic [1:0] sizes [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 6; i++) begin
      req0(rds[i], wrs[i], addrs[i], sizes[i], 1'b0, 32'h0);
      tick();
      idle0();
      expected = {3'b101, last0};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL illegal_%0d: got %h, expected %h", i, observed, expected);
      end
      tick();
      expected = {3'b100, last0};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL illegal_clear_%0d: got %h, expected %h", i, observed, expected);
      end
    end
    req0(1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
    tick();
    idle0();
    expected = {3'b110, 32'h12347FAB};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL lw_after_illegal: got %h, expected %h", observed, expected);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req0(1'b0, 1'b1, 8'(i * 4), 2'b10, 1'b0, 32'(i + 1));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      req0(1'b1, 1'b0, 8'(i * 4), 2'b10, 1'b0, 32'h0);
      tick();
      expected = {3'b110, 32'(i + 1)};
      observed = status0();
      assertCount++;
      if (observed !== expected) begin
        failCount++;
        $display("FAIL b2b_load_%0d: got %h, expected %h", i, observed, expected);
      end
    end
    idle0();
    tick();
    expected = {3'b100, 32'h4};
    observed = status0();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL b2b_end: got %h, expected %h", observed, expected);
    end
  endtask

  task automatic test_wait_states();
    logic [34:0] waitExp [5];
    req3(1'b0, 1'b1, 8'h10, 2'b10, 1'b0, 32'h12347FAB);
    tick();
    req3(1'b0, 1'b1, 8'h04, 2'b10, 1'b0, 32'hDEADBEEF);
    tick();
    // Held load to 0x10; address changes mid-wait and must be ignored.
    req3(1'b1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0);
    waitExp = '{{3'b000, 32'h0}, {3'b000, 32'h0}, {3'b000, 32'h0},
                {3'b110, 32'h12347FAB}, {3'b100, 32'h12347FAB}};
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) bus3.Address = 8'h04;
      if (c == 3) idle3();
      observed = status3();
      assertCount++;
      if (observed !== waitExp[c]) begin
        failCount++;
        $display("FAIL wait_cycle_%0d: got %h, expected %h", c, observed, waitExp[c]);
      end
    end
    // Reset during the wait aborts the load.
    req3(1'b1, 1'b0, 8'h04, 2'b10, 1'b0, 32'h0);
    waitExp = '{{3'b000, 32'h12347FAB}, {3'b000, 32'h12347FAB}, {3'b100, 32'h0},
                {3'b100, 32'h0}, {3'b100, 32'h0}};
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) idle3();
      if (c == 1) Reset = 1'b1;
      if (c == 2) Reset = 1'b0;
      observed = status3();
      assertCount++;
      if (observed !== waitExp[c]) begin
        failCount++;
        $display("FAIL wait_reset_%0d: got %h, expected %h", c, observed, waitExp[c]);
      end
    end
    req3(1'b1, 1'b0, 8'h11, 2'b10, 1'b0, 32'h0);
    tick();
    idle3();
    expected = {3'b101, 32'h0};
    observed = status3();
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL wait_illegal: got %h, expected %h", observed, expected);
    end
    req3(1'b1, 1'b0, 8'h04, 2'b10, 1'b0, 32'h0);
    waitExp = '{{3'b000, 32'h0}, {3'b000, 32'h0}, {3'b000, 32'h0},
                {3'b110, 32'hDEADBEEF}, {3'b100, 32'hDEADBEEF}};
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) idle3();
      observed = status3();
      assertCount++;
      if (observed !== waitExp[c]) begin
        failCount++;
        $display("FAIL wait_after_reset_%0d: got %h, expected %h", c, observed, waitExp[c]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus0.MemoryRead = 1'b0; bus0.MemoryWrite = 1'b0; bus0.Address = 8'h0;
    bus0.Size = 2'b10; bus0.Unsigned = 1'b0; bus0.WriteData = 32'h0;
    bus3.MemoryRead = 1'b0; bus3.MemoryWrite = 1'b0; bus3.Address = 8'h0;
    bus3.Size = 2'b10; bus3.Unsigned = 1'b0; bus3.WriteData = 32'h0;
    test_reset();
    test_load_store();
    test_partial_store();
    test_illegal();
    test_back_to_back();
    test_wait_states();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
